// File: rtl/fifo_read_serializer.sv
// Pops PAR_READ-word groups from an upstream FIFO and emits them one word per
// handshake, oldest first, counting completed groups.
module fifo_read_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int PAR_READ   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PAR_READ*DATA_WIDTH-1:0] fifo_data,
  input  logic                           fifo_empty,
  output logic                           fifo_read_enable,
  input  logic                           flush,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic [15:0]                    group_count
);

  localparam int CW = (PAR_READ > 1) ? $clog2(PAR_READ) : 1;
  localparam logic [CW-1:0] LAST = CW'(PAR_READ - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                         r_state;
  state_t                         w_nextState;
  logic [CW-1:0]                  r_cnt;
  logic [CW-1:0]                  w_nextCnt;
  logic [PAR_READ*DATA_WIDTH-1:0] r_hold;
  logic [15:0]                    r_groupCount;
  logic                           w_handshake;
  logic                           w_last;
  logic                           w_readEn;
  logic                           w_groupDone;
  logic [DATA_WIDTH-1:0]          w_outData;

  assign w_handshake = (r_state == SEND) && out_ready;
  assign w_last      = (r_cnt == LAST);
  // Gated by rst so no pop can leak out while the block is held in reset.
  assign w_readEn    = rst && !flush && !fifo_empty &&
                       ((r_state == IDLE) || (w_handshake && w_last));

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_groupDone = 1'b0;
    if (flush) begin
      w_nextState = IDLE;
      w_nextCnt   = '0;
    end else begin
      if (w_handshake) begin
        if (w_last) begin
          w_groupDone = 1'b1;
          w_nextState = IDLE;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + CW'(1);
        end
      end
      if (w_readEn) begin
        w_nextState = SEND;
        w_nextCnt   = '0;
      end
    end
  end

  always_comb begin
    w_outData = '0;
    if (r_state == SEND) begin
      for (int i = 0; i < PAR_READ; i++) begin
        if (r_cnt == CW'(i)) begin
          w_outData = r_hold[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_groupCount <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (w_readEn) begin
        r_hold <= fifo_data;
      end
      if (w_groupDone) begin
        r_groupCount <= r_groupCount + 16'd1;
      end
    end
  end

  assign fifo_read_enable = w_readEn;
  assign out_valid        = (r_state == SEND);
  assign out_data         = w_outData;
  assign busy             = (r_state == SEND);
  assign group_count      = r_groupCount;

endmodule

// File: tb/tb_fifo_read_serializer.sv
// Self-checking bench: directed vector table, back-to-back and reset sequences,
// randomized traffic against a queue-based model, and a PAR_READ=1 wrap run.
module tb_fifo_read_serializer;

  localparam int P = 4;

  logic        clk;
  logic        rst;
  logic [31:0] tbData;
  logic        tbEmpty;
  logic        tbFlush;
  logic        tbReady;
  logic        rdEn;
  logic [7:0]  outData;
  logic        outValid;
  logic        busy;
  logic [15:0] groupCount;

  logic [7:0]  p1Data;
  logic        p1Empty;
  logic        p1RdEn;
  logic [7:0]  p1Out;
  logic        p1Valid;
  logic        p1Busy;
  logic [15:0] p1Count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        empty;
    logic        ready;
    logic        flush;
    logic [31:0] data;
    logic        expRd;
    logic        expValid;
    logic [7:0]  expData;
    logic [15:0] expGc;
  } vec_t;

  vec_t vecs[$];

  logic [7:0]  mq[$];
  logic [15:0] mGc;
  logic [7:0]  pq[$];

  fifo_read_serializer #(.DATA_WIDTH(8), .PAR_READ(P)) dut (
    .clk(clk), .rst(rst), .fifo_data(tbData), .fifo_empty(tbEmpty),
    .fifo_read_enable(rdEn), .flush(tbFlush), .out_data(outData),
    .out_valid(outValid), .out_ready(tbReady), .busy(busy),
    .group_count(groupCount)
  );

  fifo_read_serializer #(.DATA_WIDTH(8), .PAR_READ(1)) dutP1 (
    .clk(clk), .rst(rst), .fifo_data(p1Data), .fifo_empty(p1Empty),
    .fifo_read_enable(p1RdEn), .flush(1'b0), .out_data(p1Out),
    .out_valid(p1Valid), .out_ready(1'b1), .busy(p1Busy),
    .group_count(p1Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s #%0d got 0x%0h want 0x%0h", name, idx, got, want);
    end
  endtask

  task automatic checkOutput(input string tag, input int idx, input logic expRd, input logic expValid,
                             input logic [7:0] expData, input logic [15:0] expGc);
    compare({tag, "_rd"},    idx, 32'(rdEn),       32'(expRd));
    compare({tag, "_valid"}, idx, 32'(outValid),   32'(expValid));
    compare({tag, "_data"},  idx, 32'(outData),    32'(expData));
    compare({tag, "_busy"},  idx, 32'(busy),       32'(expValid));
    compare({tag, "_gc"},    idx, 32'(groupCount), 32'(expGc));
  endtask

  task automatic applyStimulus(input logic empty, input logic ready, input logic flush, input logic [31:0] data);
    @(negedge clk);
    tbEmpty = empty;
    tbReady = ready;
    tbFlush = flush;
    tbData  = data;
    #1;
  endtask

  // Reference model: the held group is a queue of words still owed downstream.
  function automatic logic mRd();
    return rst && !tbFlush && !tbEmpty &&
           ((mq.size() == 0) || (tbReady && mq.size() == 1));
  endfunction

  task automatic checkModel(input string tag, input int idx);
    logic [7:0] expData;
    expData = (mq.size() != 0) ? mq[0] : 8'h00;
    checkOutput(tag, idx, mRd(), mq.size() != 0, expData, mGc);
  endtask

  task automatic advanceModel();
    logic rdNow;
    rdNow = mRd();
    @(posedge clk);
    if (tbFlush) begin
      mq.delete();
    end else begin
      if (mq.size() != 0 && tbReady) begin
        void'(mq.pop_front());
        if (mq.size() == 0) mGc = mGc + 16'd1;
      end
      if (rdNow) begin
        for (int i = 0; i < P; i++) mq.push_back(tbData[i*8 +: 8]);
      end
    end
  endtask

  task automatic addVec(input logic e, input logic r, input logic f, input logic [31:0] d,
                        input logic xr, input logic xv, input logic [7:0] xd, input logic [15:0] xg);
    vec_t v;
    v.empty = e; v.ready = r; v.flush = f; v.data = d;
    v.expRd = xr; v.expValid = xv; v.expData = xd; v.expGc = xg;
    vecs.push_back(v);
  endtask

  initial begin
    int hs;
    int iter;
    logic [31:0] da;
    logic [31:0] db;
    da = 32'h44332211;
    db = 32'h88776655;
    mGc = 16'd0;

    rst = 1'b0; tbEmpty = 1'b0; tbReady = 1'b1; tbFlush = 1'b0; tbData = da;
    p1Empty = 1'b1; p1Data = 8'h00;
    #3;
    checkOutput("reset", 0, 1'b0, 1'b0, 8'h00, 16'd0);
    compare("reset_p1rd", 0, 32'(p1RdEn), 32'd0);
    @(negedge clk);
    tbEmpty = 1'b1;
    rst = 1'b1;

    // single group, back-pressure, then flush during word 2
    addVec(1'b1, 1'b1, 1'b0, da, 1'b0, 1'b0, 8'h00, 16'd0);
    addVec(1'b0, 1'b1, 1'b0, da, 1'b1, 1'b0, 8'h00, 16'd0);
    addVec(1'b1, 1'b1, 1'b0, da, 1'b0, 1'b1, 8'h11, 16'd0);
    addVec(1'b1, 1'b0, 1'b0, da, 1'b0, 1'b1, 8'h22, 16'd0);
    addVec(1'b1, 1'b0, 1'b0, da, 1'b0, 1'b1, 8'h22, 16'd0);
    addVec(1'b1, 1'b0, 1'b0, da, 1'b0, 1'b1, 8'h22, 16'd0);
    addVec(1'b1, 1'b1, 1'b0, da, 1'b0, 1'b1, 8'h22, 16'd0);
    addVec(1'b1, 1'b1, 1'b0, da, 1'b0, 1'b1, 8'h33, 16'd0);
    addVec(1'b1, 1'b1, 1'b0, da, 1'b0, 1'b1, 8'h44, 16'd0);
    addVec(1'b1, 1'b1, 1'b0, da, 1'b0, 1'b0, 8'h00, 16'd1);
    addVec(1'b0, 1'b1, 1'b0, db, 1'b1, 1'b0, 8'h00, 16'd1);
    addVec(1'b0, 1'b1, 1'b0, db, 1'b0, 1'b1, 8'h55, 16'd1);
    addVec(1'b0, 1'b1, 1'b0, db, 1'b0, 1'b1, 8'h66, 16'd1);
    addVec(1'b0, 1'b1, 1'b1, db, 1'b0, 1'b1, 8'h77, 16'd1);
    addVec(1'b0, 1'b1, 1'b0, db, 1'b1, 1'b0, 8'h00, 16'd1);
    addVec(1'b1, 1'b1, 1'b0, db, 1'b0, 1'b1, 8'h55, 16'd1);
    addVec(1'b1, 1'b1, 1'b0, db, 1'b0, 1'b1, 8'h66, 16'd1);
    addVec(1'b1, 1'b1, 1'b0, db, 1'b0, 1'b1, 8'h77, 16'd1);
    addVec(1'b1, 1'b1, 1'b0, db, 1'b0, 1'b1, 8'h88, 16'd1);
    addVec(1'b1, 1'b1, 1'b0, db, 1'b0, 1'b0, 8'h00, 16'd2);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].empty, vecs[i].ready, vecs[i].flush, vecs[i].data);
      checkOutput("vec", i, vecs[i].expRd, vecs[i].expValid, vecs[i].expData, vecs[i].expGc);
      advanceModel();
    end

    // three groups back to back: pops at cycles 0, 4, 8 and no bubble
    for (int c = 0; c <= 13; c++) begin
      int g;
      int w;
      int pg;
      logic [31:0] d;
      pg = c / 4;
      d = {8'(pg*16 + 4), 8'(pg*16 + 3), 8'(pg*16 + 2), 8'(pg*16 + 1)};
      applyStimulus(c > 8, 1'b1, 1'b0, d);
      g = (c - 1) / 4;
      w = (c - 1) % 4;
      checkOutput("b2b", c, (c == 0) || (c == 4) || (c == 8), (c >= 1) && (c <= 12),
                  ((c >= 1) && (c <= 12)) ? 8'(g*16 + w + 1) : 8'h00,
                  16'(2 + int'(c >= 5) + int'(c >= 9) + int'(c >= 13)));
      advanceModel();
    end

    for (int n = 0; n < 1500; n++) begin
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0, $urandom);
      checkModel("rand", n);
      advanceModel();
    end

    // asynchronous reset in the middle of a held group
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hDDCCBBAA);
    checkModel("arst_pre", 0);
    advanceModel();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'hDDCCBBAA);
    checkModel("arst_pre", 1);
    advanceModel();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h12345678);
    checkModel("arst_pre", 2);
    compare("arst_gc_nonzero", 0, 32'(groupCount != 16'd0), 32'd1);
    advanceModel();
    #2;
    rst = 1'b0;
    mq.delete();
    mGc = 16'd0;
    #1;
    checkOutput("arst_low", 0, 1'b0, 1'b0, 8'h00, 16'd0);
    @(posedge clk);
    #1;
    checkOutput("arst_low", 1, 1'b0, 1'b0, 8'h00, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    tbReady = 1'b1;
    tbData = 32'hA4A3A2A1;
    #1;
    checkOutput("arst_rel", 0, 1'b1, 1'b0, 8'h00, 16'd0);
    advanceModel();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("arst_rel", 1, 1'b0, 1'b1, 8'hA1, 16'd0);
    advanceModel();
    for (int n = 0; n < 6; n++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkModel("arst_post", n);
      advanceModel();
    end

    // PAR_READ=1: every handshake completes a group; run the counter to wrap
    hs = 0;
    iter = 0;
    @(negedge clk);
    p1Empty = 1'b0;
    while (hs < 65535 && iter < 70000) begin
      @(negedge clk);
      p1Data = p1Data + 8'd1;
      #1;
      iter++;
      if (p1Valid) begin
        if (pq.size() != 0) begin
          compare("p1_data", hs, 32'(p1Out), 32'(pq[0]));
          void'(pq.pop_front());
        end
        hs++;
      end
      if (p1RdEn) pq.push_back(p1Data);
    end
    compare("p1_budget", 0, 32'(hs), 32'd65535);
    @(posedge clk);
    #1;
    compare("p1_gc_max", 0, 32'(p1Count), 32'd65535);
    @(negedge clk);
    #1;
    compare("p1_valid", 0, 32'(p1Valid), 32'd1);
    compare("p1_busy", 0, 32'(p1Busy), 32'd1);
    @(posedge clk);
    #1;
    compare("p1_gc_wrap", 0, 32'(p1Count), 32'd0);
    p1Empty = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_read_serializer.md
FIFO_READ_SERIALIZER -- requirements
Module: fifo_read_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per word.
REQ-002 SHALL have parameter PAR_READ, default 4, words popped from the upstream FIFO per read; legal range 1..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fifo_data  input  PAR_READ*DATA_WIDTH  parallel FIFO read data, valid combinationally in the cycle fifo_read_enable is high; word i at bits [i*DATA_WIDTH +: DATA_WIDTH], word 0 oldest.
REQ-006 SHALL have port fifo_empty  input  1  high when the FIFO cannot supply PAR_READ words.
REQ-007 SHALL have port fifo_read_enable  output  1  pop strobe to the FIFO, one cycle per group.
REQ-008 SHALL have port flush  input  1  synchronous discard of buffered words.
REQ-009 SHALL have port out_data  output  DATA_WIDTH  serialized word.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_data when high with out_valid.
REQ-012 SHALL have port busy  output  1  high while any captured word is not yet accepted.
REQ-013 SHALL have port group_count  output  16  number of groups fully emitted since reset, wraps modulo 2^16.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (no words held), SEND (holding a group, emitting word index cnt).
REQ-015 SHALL drive fifo_read_enable combinationally = !flush && !fifo_empty && (state==IDLE || (state==SEND && out_ready && cnt==PAR_READ-1)).
REQ-016 SHALL, on any edge where fifo_read_enable is high, capture all PAR_READ words of fifo_data into a holding register, set cnt=0, and enter/stay in SEND.
REQ-017 SHALL in SEND drive out_valid=1 and out_data=held word[cnt]; in IDLE drive out_valid=0 and out_data=0.
REQ-018 SHALL hold out_data stable and cnt unchanged while out_valid=1 and out_ready=0.
REQ-019 SHALL on handshake (out_valid && out_ready) with cnt<PAR_READ-1 increment cnt by 1.
REQ-020 SHALL on handshake with cnt==PAR_READ-1 increment group_count by 1; if fifo_read_enable is high in that cycle, reload and stay in SEND with no bubble, else go to IDLE.
REQ-021 SHALL give latency: FIFO non-empty in IDLE at cycle N -> pop at cycle N, out_valid=1 with word 0 at cycle N+1.
REQ-022 SHALL sustain throughput of one word per cycle when out_ready is held high and the FIFO never empties.
REQ-023 SHALL on flush=1 (highest priority) go to IDLE, clear cnt, suppress fifo_read_enable, not count the current group, and leave group_count otherwise unchanged; a handshake in the same cycle is ignored.
REQ-024 SHALL treat cnt as $clog2(PAR_READ) bits (minimum 1) and never index beyond PAR_READ-1; for PAR_READ=1 every handshake completes a group.
REQ-025 SHALL drive busy = (state==SEND).
REQ-026 SHALL ignore fifo_empty and fifo_data when fifo_read_enable is low.

Reset
REQ-027 SHALL, while rst=0, asynchronously force state=IDLE, cnt=0, holding register=0, group_count=0, out_valid=0, out_data=0, busy=0; fifo_read_enable=0 follows from IDLE only if fifo_empty or flush, so it SHALL additionally be gated low while rst=0.
REQ-028 SHALL, on reset assertion mid-group, discard held words with no further handshake; first pop after release occurs no earlier than the first rising edge with rst=1.

Verification
REQ-029 Single group: PAR_READ=4, fifo_data={0x44,0x33,0x22,0x11}, fifo_empty falls once, out_ready=1 -> one pop, out_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles, group_count=1, return to IDLE.
REQ-030 Back-pressure: out_ready=0 for 3 cycles after word 1 -> out_data held at 0x22, out_valid=1, no pop, cnt unchanged; emission resumes on out_ready=1.
REQ-031 Back-to-back: FIFO stays non-empty, out_ready=1 for 3 groups -> pops on cycles 0,4,8, 12 contiguous valid words, no bubble, group_count=3.
REQ-032 Flush: flush=1 during word 2 with FIFO non-empty -> out_valid=0 next cycle, no pop that cycle, group_count unchanged, new group popped the cycle after flush drops.
REQ-033 Async reset: rst=0 mid-cycle during SEND -> out_valid, busy, group_count drop to 0 immediately without a clock edge; fifo_read_enable=0 while rst=0.
REQ-034 Wrap: preload 65535 completed groups (or force) then one more group -> group_count=0.
